// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream and writes big-endian 16-bit words
// into instruction memory, releasing the CPU only after the frame checksum matches.
module imem_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 256,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    logic [1:0]  rst_sync_q;
    logic        run;

    state_t      state_q, state_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [7:0]  data_hi_q, data_hi_d;
    logic [7:0]  chk_q, chk_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        in_ready_q, in_ready_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        xfer;
    logic [15:0] len_w;

    // Reset asserts asynchronously but releases through two flops, so the FSM
    // leaves reset no earlier than the second clock edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign run = rst_sync_q[1];

    assign xfer  = in_valid & in_ready_q;
    assign len_w = {len_hi_q, in_data};

    always_comb begin
        state_d   = state_q;
        len_hi_d  = len_hi_q;
        data_hi_d = data_hi_q;
        chk_d     = chk_q;
        rem_d     = rem_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        addr_d    = we_q ? addr_q + 16'd2 : addr_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_SYNC;
                    addr_d  = BASE_ADDR;
                    chk_d   = 8'h00;
                end
            end
            S_SYNC: if (xfer && in_data == SYNC_BYTE) state_d = S_LEN_HI;
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = in_data;
                    chk_d    = chk_q ^ in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    chk_d = chk_q ^ in_data;
                    rem_d = len_w;
                    if (len_w == 16'd0)             state_d = S_CHECK;
                    else if ({1'b0, len_w} > MAX_W) state_d = S_ERROR;
                    else                            state_d = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (xfer) begin
                    data_hi_d = in_data;
                    chk_d     = chk_q ^ in_data;
                    state_d   = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (xfer) begin
                    chk_d   = chk_q ^ in_data;
                    wdata_d = {data_hi_q, in_data};
                    we_d    = 1'b1;
                    rem_d   = rem_q - 16'd1;
                    state_d = (rem_q == 16'd1) ? S_CHECK : S_DATA_HI;
                end
            end
            S_CHECK: begin
                if (xfer) state_d = (in_data == chk_q) ? S_DONE : S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase

        if (!run) begin
            state_d   = S_IDLE;
            len_hi_d  = 8'h00;
            data_hi_d = 8'h00;
            chk_d     = 8'h00;
            rem_d     = 16'd0;
            wdata_d   = 16'h0000;
            we_d      = 1'b0;
            addr_d    = BASE_ADDR;
        end

        // Status outputs are registered copies of the next state.
        in_ready_d = (state_d == S_SYNC) || (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DATA_HI) || (state_d == S_DATA_LO) || (state_d == S_CHECK);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERROR);
        cpu_hold_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_hi_q   <= 8'h00;
            data_hi_q  <= 8'h00;
            chk_q      <= 8'h00;
            rem_q      <= 16'd0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 16'h0000;
            we_q       <= 1'b0;
            in_ready_q <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            data_hi_q  <= data_hi_d;
            chk_q      <= chk_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            in_ready_q <= in_ready_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
